// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: ALUOp encodings, control-vector bit
// positions and the operand-forwarding select encoding.
package mips_pkg;

    localparam logic [1:0] ALUOP_RTYPE = 2'b00;
    localparam logic [1:0] ALUOP_IMM   = 2'b01;
    localparam logic [1:0] ALUOP_BEQ   = 2'b10;
    localparam logic [1:0] ALUOP_BNE   = 2'b11;

    localparam int unsigned CTRL_W        = 6;
    localparam int unsigned CTRL_ALUSRC   = 5;
    localparam int unsigned CTRL_REGDST   = 4;
    localparam int unsigned CTRL_REGWRITE = 3;
    localparam int unsigned CTRL_MEMREAD  = 2;
    localparam int unsigned CTRL_MEMWRITE = 1;
    localparam int unsigned CTRL_MEMTOREG = 0;

    typedef enum logic [1:0] {
        FWD_REG = 2'd0,
        FWD_WB  = 2'd1,
        FWD_MEM = 2'd2
    } fwd_sel_e;

endpackage

// File: rtl/id_ex_stage_forward_mux.sv
// Per-operand forwarding mux: MEM result beats WB result beats the registered
// register-file value; register 0 is never forwarded.
module forward_mux
    import mips_pkg::*;
#(
    parameter int unsigned DW = 32,
    parameter int unsigned RW = 5
) (
    input  logic [RW-1:0] src_i,
    input  logic          mem_we_i,
    input  logic [RW-1:0] mem_idx_i,
    input  logic [DW-1:0] mem_data_i,
    input  logic          wb_we_i,
    input  logic [RW-1:0] wb_idx_i,
    input  logic [DW-1:0] wb_data_i,
    input  logic [DW-1:0] reg_val_i,
    output logic [DW-1:0] operand_o,
    output fwd_sel_e      sel_o
);

    always_comb begin
        sel_o = FWD_REG;
        if (mem_we_i && (mem_idx_i == src_i) && (src_i != '0)) begin
            sel_o = FWD_MEM;
        end else if (wb_we_i && (wb_idx_i == src_i) && (src_i != '0)) begin
            sel_o = FWD_WB;
        end
    end

    always_comb begin
        operand_o = reg_val_i;
        case (sel_o)
            FWD_MEM: operand_o = mem_data_i;
            FWD_WB:  operand_o = wb_data_i;
            default: operand_o = reg_val_i;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU, with MEM/WB operand forwarding,
// load-use stall detection and bubble insertion on stall or flush.
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int unsigned DW = 32,
    parameter int unsigned RW = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          id_valid,
    input  logic [DW-1:0] id_RD1,
    input  logic [DW-1:0] id_RD2,
    input  logic [DW-1:0] id_SignImm,
    input  logic [4:0]    id_sa,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic [RW-1:0] id_rd,
    input  logic [1:0]    id_ALUOp,
    input  logic [5:0]    id_funct,
    input  logic [5:0]    id_ctrl,
    input  logic          mem_RegWrite,
    input  logic [RW-1:0] mem_WriteReg,
    input  logic [DW-1:0] mem_ALUResult,
    input  logic          wb_RegWrite,
    input  logic [RW-1:0] wb_WriteReg,
    input  logic [DW-1:0] wb_Result,
    input  logic          flush,
    output logic          stall,
    output logic          ex_valid,
    output logic [DW-1:0] ex_SrcA,
    output logic [DW-1:0] ex_RD2,
    output logic [DW-1:0] ex_SignImm,
    output logic [4:0]    ex_sa,
    output logic [1:0]    ex_ALUOp,
    output logic [5:0]    ex_funct,
    output logic          ex_ALUSrc,
    output logic [RW-1:0] ex_WriteReg,
    output logic          ex_RegWrite,
    output logic          ex_MemRead,
    output logic          ex_MemWrite,
    output logic          ex_MemtoReg
);

    logic                valid_q, valid_d;
    logic [DW-1:0]       rd1_q, rd1_d;
    logic [DW-1:0]       rd2_q, rd2_d;
    logic [DW-1:0]       simm_q, simm_d;
    logic [4:0]          sa_q, sa_d;
    logic [RW-1:0]       rs_q, rs_d;
    logic [RW-1:0]       rt_q, rt_d;
    logic [RW-1:0]       wreg_q, wreg_d;
    logic [1:0]          aluop_q, aluop_d;
    logic [5:0]          funct_q, funct_d;
    logic [CTRL_W-1:0]   ctrl_q, ctrl_d;

    fwd_sel_e            sel_a, sel_b;
    logic                unused_fwd_sel;

    always_comb begin
        stall = valid_q && ctrl_q[CTRL_MEMREAD] && (rt_q != '0)
             && ((rt_q == id_rs) || (rt_q == id_rt))
             && id_valid && !flush;
    end

    // Bubble is all-zero; a non-valid decode slot still captures data but no ctrl.
    always_comb begin
        valid_d = 1'b0;
        rd1_d   = '0;
        rd2_d   = '0;
        simm_d  = '0;
        sa_d    = '0;
        rs_d    = '0;
        rt_d    = '0;
        wreg_d  = '0;
        aluop_d = '0;
        funct_d = '0;
        ctrl_d  = '0;
        if (!(flush || stall)) begin
            valid_d = id_valid;
            rd1_d   = id_RD1;
            rd2_d   = id_RD2;
            simm_d  = id_SignImm;
            sa_d    = id_sa;
            rs_d    = id_rs;
            rt_d    = id_rt;
            wreg_d  = id_ctrl[CTRL_REGDST] ? id_rd : id_rt;
            aluop_d = id_ALUOp;
            funct_d = id_funct;
            ctrl_d  = id_valid ? id_ctrl : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            rd1_q   <= '0;
            rd2_q   <= '0;
            simm_q  <= '0;
            sa_q    <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            wreg_q  <= '0;
            aluop_q <= '0;
            funct_q <= '0;
            ctrl_q  <= '0;
        end else begin
            valid_q <= valid_d;
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
            simm_q  <= simm_d;
            sa_q    <= sa_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            wreg_q  <= wreg_d;
            aluop_q <= aluop_d;
            funct_q <= funct_d;
            ctrl_q  <= ctrl_d;
        end
    end

    forward_mux #(.DW(DW), .RW(RW)) u_fwd_a (
        .src_i      (rs_q),
        .mem_we_i   (mem_RegWrite),
        .mem_idx_i  (mem_WriteReg),
        .mem_data_i (mem_ALUResult),
        .wb_we_i    (wb_RegWrite),
        .wb_idx_i   (wb_WriteReg),
        .wb_data_i  (wb_Result),
        .reg_val_i  (rd1_q),
        .operand_o  (ex_SrcA),
        .sel_o      (sel_a)
    );

    forward_mux #(.DW(DW), .RW(RW)) u_fwd_b (
        .src_i      (rt_q),
        .mem_we_i   (mem_RegWrite),
        .mem_idx_i  (mem_WriteReg),
        .mem_data_i (mem_ALUResult),
        .wb_we_i    (wb_RegWrite),
        .wb_idx_i   (wb_WriteReg),
        .wb_data_i  (wb_Result),
        .reg_val_i  (rd2_q),
        .operand_o  (ex_RD2),
        .sel_o      (sel_b)
    );

    // Selects are only observed in waveforms; the operands carry the result.
    assign unused_fwd_sel = ^{sel_a, sel_b};

    assign ex_valid    = valid_q;
    assign ex_SignImm  = simm_q;
    assign ex_sa       = sa_q;
    assign ex_ALUOp    = aluop_q;
    assign ex_funct    = funct_q;
    assign ex_ALUSrc   = ctrl_q[CTRL_ALUSRC];
    assign ex_WriteReg = wreg_q;
    assign ex_RegWrite = ctrl_q[CTRL_REGWRITE];
    assign ex_MemRead  = ctrl_q[CTRL_MEMREAD];
    assign ex_MemWrite = ctrl_q[CTRL_MEMWRITE];
    assign ex_MemtoReg = ctrl_q[CTRL_MEMTOREG];

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, capture, forwarding priority,
// register-0 exclusion, load-use stall, flush and destination select.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [31:0] id_RD1, id_RD2, id_SignImm;
    logic [4:0]  id_sa, id_rs, id_rt, id_rd;
    logic [1:0]  id_ALUOp;
    logic [5:0]  id_funct, id_ctrl;
    logic        mem_RegWrite, wb_RegWrite, flush;
    logic [4:0]  mem_WriteReg, wb_WriteReg;
    logic [31:0] mem_ALUResult, wb_Result;
    logic        stall, ex_valid, ex_ALUSrc;
    logic [31:0] ex_SrcA, ex_RD2, ex_SignImm;
    logic [4:0]  ex_sa, ex_WriteReg;
    logic [1:0]  ex_ALUOp;
    logic [5:0]  ex_funct;
    logic        ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemtoReg;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    id_ex_stage #(.DW(32), .RW(5)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_RD1(id_RD1), .id_RD2(id_RD2), .id_SignImm(id_SignImm), .id_sa(id_sa),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_ALUOp(id_ALUOp), .id_funct(id_funct), .id_ctrl(id_ctrl),
        .mem_RegWrite(mem_RegWrite), .mem_WriteReg(mem_WriteReg), .mem_ALUResult(mem_ALUResult),
        .wb_RegWrite(wb_RegWrite), .wb_WriteReg(wb_WriteReg), .wb_Result(wb_Result),
        .flush(flush), .stall(stall), .ex_valid(ex_valid),
        .ex_SrcA(ex_SrcA), .ex_RD2(ex_RD2), .ex_SignImm(ex_SignImm), .ex_sa(ex_sa),
        .ex_ALUOp(ex_ALUOp), .ex_funct(ex_funct), .ex_ALUSrc(ex_ALUSrc),
        .ex_WriteReg(ex_WriteReg), .ex_RegWrite(ex_RegWrite), .ex_MemRead(ex_MemRead),
        .ex_MemWrite(ex_MemWrite), .ex_MemtoReg(ex_MemtoReg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet_fwd();
        mem_RegWrite = 1'b0; mem_WriteReg = '0; mem_ALUResult = '0;
        wb_RegWrite  = 1'b0; wb_WriteReg  = '0; wb_Result     = '0;
        flush = 1'b0;
    endtask

    task automatic drive_id(input logic v, input logic [5:0] ctrl, input logic [4:0] rs,
                            input logic [4:0] rt, input logic [4:0] rd,
                            input logic [31:0] r1, input logic [31:0] r2);
        id_valid = v; id_ctrl = ctrl; id_rs = rs; id_rt = rt; id_rd = rd;
        id_RD1 = r1; id_RD2 = r2;
    endtask

    task automatic check_bubble(input string tag);
        check({tag, "_valid"},    32'(ex_valid),    32'd0);
        check({tag, "_regwrite"}, 32'(ex_RegWrite), 32'd0);
        check({tag, "_memread"},  32'(ex_MemRead),  32'd0);
        check({tag, "_memwrite"}, 32'(ex_MemWrite), 32'd0);
    endtask

    initial begin
        // Reset with arbitrary decode inputs and a register-0 forward source.
        reset = 1'b1;
        drive_id(1'b1, 6'b111111, 5'd0, 5'd0, 5'd7, 32'hDEAD_BEEF, 32'hCAFE_F00D);
        id_SignImm = 32'h1111_2222; id_sa = 5'd31; id_ALUOp = 2'b11; id_funct = 6'h3F;
        quiet_fwd();
        mem_RegWrite = 1'b1; mem_ALUResult = 32'h99; wb_RegWrite = 1'b1; wb_Result = 32'h77;
        tick(); tick();
        check("rst_valid",   32'(ex_valid),    32'd0);
        check("rst_srca",    ex_SrcA,          32'd0);
        check("rst_rd2",     ex_RD2,           32'd0);
        check("rst_simm",    ex_SignImm,       32'd0);
        check("rst_wreg",    32'(ex_WriteReg), 32'd0);
        check("rst_ctrl",    32'({ex_ALUSrc, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemtoReg}), 32'd0);
        check("rst_aluop",   32'({ex_ALUOp, ex_funct, ex_sa}), 32'd0);
        check("rst_stall",   32'(stall),       32'd0);

        // Release reset and capture an R-type instruction.
        reset = 1'b0;
        quiet_fwd();
        drive_id(1'b1, 6'b011000, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7);
        id_SignImm = 32'h10; id_sa = 5'd4; id_ALUOp = 2'b00; id_funct = 6'h20;
        tick();
        check("cap_valid", 32'(ex_valid),    32'd1);
        check("cap_srca",  ex_SrcA,          32'd5);
        check("cap_rd2",   ex_RD2,           32'd7);
        check("cap_wreg",  32'(ex_WriteReg), 32'd3);
        check("cap_rw",    32'(ex_RegWrite), 32'd1);
        check("cap_funct", 32'(ex_funct),    32'h20);
        check("cap_sa",    32'(ex_sa),       32'd4);
        check("cap_simm",  ex_SignImm,       32'h10);

        // addi-style instruction: rs=3, rt=0.
        drive_id(1'b1, 6'b101000, 5'd3, 5'd0, 5'd0, 32'h11, 32'h22);
        id_ALUOp = 2'b01;
        tick();
        check("imm_alusrc", 32'(ex_ALUSrc), 32'd1);
        check("imm_aluop",  32'(ex_ALUOp),  32'd1);
        mem_RegWrite = 1'b1; mem_WriteReg = 5'd3; mem_ALUResult = 32'hAA;
        wb_RegWrite  = 1'b1; wb_WriteReg  = 5'd3; wb_Result     = 32'hBB;
        #1 check("fwd_mem_prio", ex_SrcA, 32'hAA);
        mem_RegWrite = 1'b0;
        #1 check("fwd_wb", ex_SrcA, 32'hBB);
        wb_RegWrite = 1'b0;
        #1 check("fwd_none", ex_SrcA, 32'h11);
        mem_RegWrite = 1'b1; mem_WriteReg = 5'd0; mem_ALUResult = 32'h55;
        wb_RegWrite  = 1'b1; wb_WriteReg  = 5'd0; wb_Result     = 32'h66;
        #1 check("fwd_r0_rd2", ex_RD2, 32'h22);
        check("fwd_r0_srca", ex_SrcA, 32'h11);
        quiet_fwd();

        // Load-use: lw rt=8 in EX, consumer reads r8 in decode.
        drive_id(1'b1, 6'b101101, 5'd2, 5'd8, 5'd0, 32'h100, 32'h0);
        id_SignImm = 32'd4;
        tick();
        check("lw_memread", 32'(ex_MemRead),  32'd1);
        check("lw_wreg",    32'(ex_WriteReg), 32'd8);
        check("lw_m2r",     32'(ex_MemtoReg), 32'd1);
        drive_id(1'b1, 6'b011000, 5'd8, 5'd9, 5'd10, 32'h0, 32'h33);
        id_ALUOp = 2'b00;
        #1 check("lu_stall", 32'(stall), 32'd1);
        tick();
        check_bubble("lu_bubble");
        check("lu_stall_clr", 32'(stall), 32'd0);
        tick();
        wb_RegWrite = 1'b1; wb_WriteReg = 5'd8; wb_Result = 32'h1234;
        #1 check("lu_reissue_v", 32'(ex_valid), 32'd1);
        check("lu_wb_srca", ex_SrcA, 32'h1234);
        check("lu_rd2",     ex_RD2,  32'h33);
        check("lu_wreg",    32'(ex_WriteReg), 32'd10);
        check("lu_nostall", 32'(stall), 32'd0);
        quiet_fwd();

        // Flush beats a load-use hazard on an sw in decode (hazard via rt).
        drive_id(1'b1, 6'b101101, 5'd2, 5'd8, 5'd0, 32'h100, 32'h0);
        tick();
        drive_id(1'b1, 6'b100010, 5'd1, 5'd8, 5'd0, 32'h40, 32'h50);
        #1 check("fl_pre_stall", 32'(stall), 32'd1);
        flush = 1'b1;
        #1 check("fl_stall", 32'(stall), 32'd0);
        tick();
        check_bubble("fl_bubble");
        flush = 1'b0;

        // Destination select.
        drive_id(1'b1, 6'b011000, 5'd1, 5'd4, 5'd9, 32'h1, 32'h2);
        tick();
        check("dst_rd", 32'(ex_WriteReg), 32'd9);
        drive_id(1'b1, 6'b001000, 5'd1, 5'd4, 5'd9, 32'h1, 32'h2);
        tick();
        check("dst_rt", 32'(ex_WriteReg), 32'd4);

        // Invalid decode slot carries no side effects.
        drive_id(1'b0, 6'b111111, 5'd1, 5'd4, 5'd9, 32'h1, 32'h2);
        tick();
        check("inv_valid", 32'(ex_valid), 32'd0);
        check("inv_ctrl",  32'({ex_ALUSrc, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemtoReg}), 32'd0);
        check("inv_srca",  ex_SrcA, 32'h1);

        // Reset during a stall clears everything.
        drive_id(1'b1, 6'b101101, 5'd2, 5'd8, 5'd0, 32'h100, 32'h0);
        tick();
        drive_id(1'b1, 6'b011000, 5'd8, 5'd9, 5'd10, 32'h7, 32'h33);
        #1 check("rs_stall", 32'(stall), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_bubble("rs_clear");
        check("rs_wreg", 32'(ex_WriteReg), 32'd0);
        check("rs_srca", ex_SrcA, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
